// File: rtl/huff_decoder.sv
// huff_decoder: bit-serial Huffman stream decoder with a loadable code table.
module huff_decoder #(
    parameter int TABLE_SIZE   = 32,
    parameter int MAX_CODE_LEN = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          tableWrite,
    input  logic [$clog2(TABLE_SIZE)-1:0] tableIndex,
    input  logic [31:0]                   symbol,
    input  logic [7:0]                    symbolLength,
    input  logic [7:0]                    character,
    input  logic [31:0]                   wordIn,
    input  logic                          wordValid,
    output logic                          wordReady,
    output logic [7:0]                    charOut,
    output logic                          charValid,
    input  logic                          charReady,
    output logic                          done,
    output logic                          error,
    output logic [15:0]                   log
);
    localparam int indexWidth = $clog2(TABLE_SIZE);
    localparam int lenWidth   = $clog2(MAX_CODE_LEN + 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] HEADER = 3'd1;
    localparam logic [2:0] DECODE = 3'd2;
    localparam logic [2:0] FETCH  = 3'd3;
    localparam logic [2:0] EMIT   = 3'd4;
    localparam logic [2:0] DONE   = 3'd5;
    localparam logic [2:0] ERROR  = 3'd6;

    logic [2:0]            state;
    logic [15:0]           bitsLeft;
    logic [31:0]           buffer;
    logic [4:0]            bitPos;
    logic                  bufEmpty;
    logic [31:0]           code;
    logic [lenWidth-1:0]   codeLen;
    logic [31:0]           tabSym  [TABLE_SIZE];
    logic [7:0]            tabLen  [TABLE_SIZE];
    logic [7:0]            tabChar [TABLE_SIZE];

    logic                  curBit;
    logic [31:0]           nextCode;
    logic [lenWidth-1:0]   nextLen;
    logic [31:0]           lenMask;
    logic                  hit;
    logic [indexWidth-1:0] hitIdx;

    assign curBit   = buffer[bitPos];
    assign nextCode = {code[30:0], curBit};
    assign nextLen  = codeLen + lenWidth'(1);
    assign lenMask  = ~(32'hFFFF_FFFF << nextLen);

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        hit    = 1'b0;
        hitIdx = '0;
        for (int i = TABLE_SIZE - 1; i >= 0; i--) begin
            if (tabLen[i] == 8'(nextLen) && (tabSym[i] & lenMask) == nextCode) begin
                hit    = 1'b1;
                hitIdx = indexWidth'(i);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (state == IDLE && tableWrite) begin
            tabSym[tableIndex]  <= symbol;
            tabChar[tableIndex] <= character;
        end
    end

    // Only the length field needs clearing: length 0 marks an entry invalid.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < TABLE_SIZE; i++) tabLen[i] <= '0;
        end else if (state == IDLE && tableWrite) begin
            tabLen[tableIndex] <= symbolLength;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            bitsLeft <= '0;
            buffer   <= '0;
            bitPos   <= '0;
            bufEmpty <= 1'b0;
            code     <= '0;
            codeLen  <= '0;
            charOut  <= '0;
        end else begin
            case (state)
                IDLE: if (start) state <= HEADER;
                HEADER: if (wordValid) begin
                    bitsLeft <= wordIn[31:16];
                    buffer   <= {16'h0, wordIn[15:0]};
                    bitPos   <= 5'd15;
                    bufEmpty <= 1'b0;
                    code     <= '0;
                    codeLen  <= '0;
                    state    <= (wordIn[31:16] == 16'd0) ? DONE : DECODE;
                end
                FETCH: if (wordValid) begin
                    buffer   <= wordIn;
                    bitPos   <= 5'd31;
                    bufEmpty <= 1'b0;
                    state    <= DECODE;
                end
                DECODE: begin
                    code     <= nextCode;
                    codeLen  <= nextLen;
                    bitsLeft <= bitsLeft - 16'd1;
                    bitPos   <= bitPos - 5'd1;
                    bufEmpty <= (bitPos == 5'd0);
                    if (hit) begin
                        charOut <= tabChar[hitIdx];
                        state   <= EMIT;
                    end else if (nextLen >= lenWidth'(MAX_CODE_LEN)) begin
                        state <= ERROR;
                    end else if (bitsLeft == 16'd1) begin
                        state <= ERROR;
                    end else if (bitPos == 5'd0) begin
                        state <= FETCH;
                    end
                end
                EMIT: if (charReady) begin
                    code    <= '0;
                    codeLen <= '0;
                    state   <= (bitsLeft == 16'd0) ? DONE : bufEmpty ? FETCH : DECODE;
                end
                DONE:    state <= IDLE;
                ERROR:   if (start) state <= HEADER;
                default: state <= IDLE;
            endcase
        end
    end

    assign wordReady = (state == HEADER) || (state == FETCH);
    assign charValid = (state == EMIT);
    assign done      = (state == DONE);
    assign error     = (state == ERROR);
    assign log       = {13'd0, state};
endmodule

// File: tb/tb_huff_decoder.sv
// tb_huff_decoder: random and directed decode runs checked against a bit-list reference decoder.
module tb_huff_decoder;
    localparam int MAXLEN = 16;

    logic        clock = 0, reset = 0, start = 0, tableWrite = 0;
    logic [4:0]  tableIndex = 0;
    logic [31:0] symbol = 0;
    logic [7:0]  symbolLength = 0, character = 0;
    logic [31:0] wordIn = 0;
    logic        wordValid = 0, wordReady;
    logic [7:0]  charOut;
    logic        charValid, charReady = 1, done, error;
    logic [15:0] log;

    huff_decoder #(.TABLE_SIZE(32), .MAX_CODE_LEN(MAXLEN)) dut (
        .clock(clock), .reset(reset), .start(start), .tableWrite(tableWrite),
        .tableIndex(tableIndex), .symbol(symbol), .symbolLength(symbolLength),
        .character(character), .wordIn(wordIn), .wordValid(wordValid), .wordReady(wordReady),
        .charOut(charOut), .charValid(charValid), .charReady(charReady),
        .done(done), .error(error), .log(log)
    );

    always #5 clock = ~clock;

    int          total = 0, bad = 0;
    logic [31:0] tSym [32];
    logic [7:0]  tLen [32];
    logic [7:0]  tChr [32];
    bit          msgBits[$];
    logic [7:0]  expChars[$], gotQ[$];
    logic [31:0] wordQ[$];
    int          cyc, hdrCyc, stallReq, nFetch;
    logic [7:0]  holdChar;
    bit          expErr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        bit wx, cx;
        wx = wordValid && wordReady;
        cx = charValid && charReady;
        if (cx) gotQ.push_back(charOut);
        if (charValid && !charReady) check("hold", charOut, holdChar);
        if (wx && hdrCyc < 0) hdrCyc = cyc;
        @(posedge clock);
        #1;
        cyc++;
        start = 0;
        tableWrite = 0;
        if (wx) wordQ.delete(0);
        wordValid = wordQ.size() > 0;
        wordIn = wordValid ? wordQ[0] : 32'h0;
        if (charValid && stallReq > 0) begin
            charReady = 0;
            stallReq--;
        end else charReady = 1;
        @(negedge clock);
    endtask

    function automatic logic [31:0] lenMask(input int n);
        return (n >= 32) ? 32'hFFFF_FFFF : ((32'h1 << n) - 32'h1);
    endfunction

    // Walk the bit list, growing a candidate code and looking it up in the table.
    task automatic model();
        logic [31:0] c;
        int n, hitI;
        c = 0; n = 0; expChars = {}; expErr = 0;
        for (int p = 0; p < msgBits.size(); p++) begin
            c = c * 2 + 32'(msgBits[p]);
            n++;
            hitI = -1;
            for (int i = 0; i < 32; i++)
                if (hitI < 0 && int'(tLen[i]) == n && (tSym[i] & lenMask(n)) == c) hitI = i;
            if (hitI >= 0) begin
                expChars.push_back(tChr[hitI]);
                c = 0; n = 0;
            end else if (n >= MAXLEN || p == msgBits.size() - 1) begin
                expErr = 1;
                break;
            end
        end
    endtask

    task automatic buildWords(input bit rnd);
        int nb;
        logic [31:0] w;
        nb = msgBits.size();
        wordQ = {};
        w = {16'(nb), 16'h0};
        for (int j = 0; j < 16; j++) w[15-j] = (j < nb) ? msgBits[j] : (rnd ? 1'($urandom) : 1'b0);
        wordQ.push_back(w);
        for (int p = 16; p < nb; p += 32) begin
            for (int j = 0; j < 32; j++) w[31-j] = (p + j < nb) ? msgBits[p+j] : (rnd ? 1'($urandom) : 1'b0);
            wordQ.push_back(w);
        end
        nFetch = wordQ.size() - 1;
    endtask

    task automatic addBits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) msgBits.push_back(v[i]);
    endtask

    task automatic loadTable();
        for (int i = 0; i < 32; i++) begin
            tableWrite = 1;
            tableIndex = 5'(i);
            symbol = tSym[i];
            symbolLength = tLen[i];
            character = tChr[i];
            tick();
        end
    endtask

    task automatic setAbc(input bit withC);
        for (int i = 0; i < 32; i++) begin
            tSym[i] = 0; tLen[i] = 0; tChr[i] = 0;
        end
        tSym[0] = 32'h0; tLen[0] = 8'd1; tChr[0] = 8'h41;
        tSym[1] = 32'h2; tLen[1] = 8'd2; tChr[1] = 8'h42;
        if (withC) begin
            tSym[2] = 32'h3; tLen[2] = 8'd2; tChr[2] = 8'h43;
        end
    endtask

    task automatic runMsg(input string tag, input bit rnd, input int stall);
        int n, lat;
        model();
        buildWords(rnd);
        gotQ = {}; hdrCyc = -1; cyc = 0; stallReq = stall;
        holdChar = expChars.size() > 0 ? expChars[0] : 8'h0;
        wordValid = 1; wordIn = wordQ[0]; start = 1;
        tick();
        check({tag, " hdr"}, {error, log}, {1'b0, 16'h1});
        n = 0;
        while (!done && !error && n < 2000) begin
            tick();
            n++;
        end
        check({tag, " end"}, {done, error}, {!expErr, expErr});
        check({tag, " n"}, gotQ.size(), expChars.size());
        for (int i = 0; i < expChars.size() && i < gotQ.size(); i++) check({tag, " ch"}, gotQ[i], expChars[i]);
        if (expErr) check({tag, " log"}, log, 16'h6);
        else begin
            lat = msgBits.size() + expChars.size() + nFetch + 1 + (expChars.size() > 0 ? stall : 0);
            check({tag, " lat"}, cyc - hdrCyc, lat);
            tick();
            check({tag, " idle"}, {done, log}, 17'h0);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int idx, m, e;
        int valid[$];
        repeat (2) @(negedge clock);
        check("rst", {wordReady, charValid, charOut, done, error, log}, 28'h0);
        reset = 1;
        @(negedge clock);

        setAbc(1); loadTable();
        msgBits = {}; addBits(32'b01011, 5); runMsg("abc", 0, 0);
        msgBits = {}; addBits(32'hAAAA, 16); addBits(32'hA, 4); runMsg("tenB", 0, 0);
        msgBits = {}; runMsg("empty", 0, 0);
        msgBits = {}; addBits(32'b01011, 5); runMsg("bp", 0, 5);

        setAbc(0); loadTable();
        msgBits = {}; addBits(32'b11, 2); runMsg("trunc", 0, 0);
        msgBits = {}; repeat (20) msgBits.push_back(1'b1); runMsg("maxlen", 0, 0);
        msgBits = {}; runMsg("clr", 0, 0);

        setAbc(1); loadTable();
        msgBits = {}; addBits(32'hAAAA, 16); buildWords(0);
        wordValid = 1; wordIn = wordQ[0]; start = 1;
        tick(); tick(); tick();
        #2 reset = 0;
        #1 check("arst", {wordReady, charValid, charOut, done, error, log}, 28'h0);
        wordQ = {}; wordValid = 0; stallReq = 0; charReady = 1;
        @(negedge clock);
        reset = 1;
        @(negedge clock);
        for (int i = 0; i < 32; i++) tLen[i] = 0;
        msgBits = {1'b0}; runMsg("wiped", 0, 0);
        msgBits = {}; runMsg("wclr", 0, 0);
        setAbc(1); loadTable();
        msgBits = {}; addBits(32'b01011, 5); runMsg("rerun", 0, 0);

        for (int it = 0; it < 30; it++) begin
            valid = {};
            for (int i = 0; i < 32; i++) begin
                tLen[i] = 0; tSym[i] = $urandom; tChr[i] = 8'($urandom);
            end
            for (int k = 0; k < $urandom_range(2, 8); k++) begin
                idx = $urandom_range(0, 31);
                tLen[idx] = 8'($urandom_range(1, 5));
                valid.push_back(idx);
            end
            loadTable();
            msgBits = {};
            m = $urandom_range(0, 12);
            for (int j = 0; j < m; j++) begin
                e = valid[$urandom_range(0, valid.size() - 1)];
                addBits(tSym[e], int'(tLen[e]));
            end
            if ($urandom_range(0, 3) == 0)
                for (int j = 0; j < $urandom_range(1, 3); j++) msgBits.push_back(1'($urandom));
            runMsg("rnd", 1, ($urandom_range(0, 1) == 1) ? $urandom_range(1, 3) : 0);
            if (expErr) begin
                msgBits = {};
                runMsg("rclr", 0, 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
